// File: rtl/matrix_multiply_param.sv
// -----------------------------------------------------------------------------
// matrix_multiply_param
//
// Signed N x N matrix multiplier, R = A x B. Elements are W-bit two's
// complement. After start, one result row is produced per clock, so a
// complete product takes N+1 edges from start to done.
//
// Optional build macro: SATURATE_EN
//   defined   - each output element clamps to the W-bit signed range
//   undefined - each output element is the low W bits of the accumulator
// In both builds, overflow flags any element whose exact value did not fit.
//
// Ports
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   begin a new multiply (honoured only when idle)
//   matrix_a  in   operand A, element (r,c) at [(r*N+c)*W +: W]
//   matrix_b  in   operand B, same packing
//   result    out  product R, same packing, registered
//   busy      out  high while an operation is in progress
//   done      out  one-cycle pulse once all of R has been written
//   overflow  out  sticky per operation, valid with done
// -----------------------------------------------------------------------------
module matrix_multiply_param #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N*N*W-1:0] matrix_a,
    input  logic [N*N*W-1:0] matrix_b,
    output logic [N*N*W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int VEC_W = N * N * W;
    localparam int ROW_W = $clog2(N);
    localparam int PRD_W = 2 * W;
    // Headroom of clog2(N) bits means a sum of N full products never wraps.
    localparam int ACC_W = 2 * W + $clog2(N);

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
`endif

    typedef enum logic {
        S_IDLE,
        S_COMPUTE
    } state_e;

    state_e                  state_q;
    logic [ROW_W-1:0]        row_q;
    logic [VEC_W-1:0]        a_q;
    logic [VEC_W-1:0]        b_q;
    logic [VEC_W-1:0]        result_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    overflow_q;

    logic signed [ACC_W-1:0] acc_d [N];
    logic [N*W-1:0]          row_d;
    logic [N-1:0]            row_ovf_d;

    logic                    accept;

    assign accept = (state_q == S_IDLE) && start;

    function automatic logic signed [W-1:0] elem_at(
        input logic [VEC_W-1:0] m,
        input int               r,
        input int               c
    );
        return m[(r * N + c) * W +: W];
    endfunction

    // Dot product of row r of A with column c of B at full precision.
    function automatic logic signed [ACC_W-1:0] dot(
        input logic [VEC_W-1:0] a,
        input logic [VEC_W-1:0] b,
        input int               r,
        input int               c
    );
        logic signed [PRD_W-1:0] prod;
        logic signed [ACC_W-1:0] sum;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            // Size casts sign-extend, so the multiply is done at 2W bits.
            prod = PRD_W'(elem_at(a, r, k)) * PRD_W'(elem_at(b, k, c));
            sum  = sum + ACC_W'(prod);
        end
        return sum;
    endfunction

    // Current result row and its per-element overflow flags.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path leaves a value held and no latch is inferred.
        row_d     = '0;
        row_ovf_d = '0;
        for (int c = 0; c < N; c++) begin
            acc_d[c] = dot(a_q, b_q, int'(row_q), c);
`ifdef SATURATE_EN
            if (acc_d[c] > MAX_V) begin
                row_d[c*W +: W] = MAX_V[W-1:0];
                row_ovf_d[c]    = 1'b1;
            end else if (acc_d[c] < MIN_V) begin
                row_d[c*W +: W] = MIN_V[W-1:0];
                row_ovf_d[c]    = 1'b1;
            end else begin
                row_d[c*W +: W] = acc_d[c][W-1:0];
            end
`else
            row_d[c*W +: W] = acc_d[c][W-1:0];
            // Truncation lost information if sign-extending the kept bits
            // does not reproduce the exact sum.
            row_ovf_d[c]    = (acc_d[c] != ACC_W'($signed(acc_d[c][W-1:0])));
`endif
        end
    end

    // Operand capture. These registers are only read while COMPUTE, and
    // COMPUTE is always entered through a capture.
    // NOTE: wide data-only storage is left out of reset; only control state
    // and visible outputs need a defined value after reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_q <= matrix_a;
            b_q <= matrix_b;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_COMPUTE;
                        row_q      <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    result_q[int'(row_q) * N * W +: N * W] <= row_d;
                    if (|row_ovf_d) begin
                        overflow_q <= 1'b1;
                    end
                    if (row_q == ROW_W'(N - 1)) begin
                        row_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_matrix_multiply_param.sv
// -----------------------------------------------------------------------------
// tb_matrix_multiply_param
//
// Drives three instances of matrix_multiply_param (N=5/W=8, N=2/W=4,
// N=16/W=16) from one directed sequence with random operands, and compares
// every result element, the overflow flag and the start/busy/done timing
// against an integer reference model of the matrix product.
// -----------------------------------------------------------------------------
module tb_matrix_multiply_param;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    // Instance N=5, W=8
    logic           start5;
    logic [199:0]   a5, b5, res5;
    logic           busy5, done5, ovf5;
    // Instance N=2, W=4
    logic           start2;
    logic [15:0]    a2, b2, res2;
    logic           busy2, done2, ovf2;
    // Instance N=16, W=16
    logic           start16;
    logic [4095:0]  a16, b16, res16;
    logic           busy16, done16, ovf16;

    matrix_multiply_param #(.N(5), .W(8)) dut5 (
        .clock(clock), .reset_n(reset_n), .start(start5),
        .matrix_a(a5), .matrix_b(b5), .result(res5),
        .busy(busy5), .done(done5), .overflow(ovf5)
    );

    matrix_multiply_param #(.N(2), .W(4)) dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2),
        .matrix_a(a2), .matrix_b(b2), .result(res2),
        .busy(busy2), .done(done2), .overflow(ovf2)
    );

    matrix_multiply_param #(.N(16), .W(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .start(start16),
        .matrix_a(a16), .matrix_b(b16), .result(res16),
        .busy(busy16), .done(done16), .overflow(ovf16)
    );

    // Selected instance, outputs zero-extended to the widest instance.
    int            sel;
    logic [4095:0] cur_res;
    logic          cur_busy, cur_done, cur_ovf;

    always_comb begin
        cur_res  = '0;
        cur_busy = 1'b0;
        cur_done = 1'b0;
        cur_ovf  = 1'b0;
        case (sel)
            0: begin
                cur_res[199:0] = res5;
                cur_busy = busy5; cur_done = done5; cur_ovf = ovf5;
            end
            1: begin
                cur_res[15:0] = res2;
                cur_busy = busy2; cur_done = done2; cur_ovf = ovf2;
            end
            default: begin
                cur_res  = res16;
                cur_busy = busy16; cur_done = done16; cur_ovf = ovf16;
            end
        endcase
    end

    int passes = 0;
    int checks = 0;

    // Reference matrices: [0]=A, [1]=B, [2]=expected R. Plus expected overflow.
    longint mats [3][16][16];
    bit     exp_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       start5  = v;
            1:       start2  = v;
            default: start16 = v;
        endcase
    endtask

    task automatic set_ops(input int s, input logic [4095:0] av, input logic [4095:0] bv);
        case (s)
            0:       begin a5  = av[199:0]; b5  = bv[199:0]; end
            1:       begin a2  = av[15:0];  b2  = bv[15:0];  end
            default: begin a16 = av;        b16 = bv;        end
        endcase
    endtask

    function automatic logic [4095:0] rand_vec();
        logic [4095:0] v;
        for (int i = 0; i < 128; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic longint rand_elem(input int w);
        return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w - 1));
    endfunction

    function automatic logic [4095:0] pack_mat(input int which, input int n, input int w);
        logic [4095:0] v;
        v = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int b = 0; b < w; b++)
                    v[(r * n + c) * w + b] = mats[which][r][c][b];
        return v;
    endfunction

    task automatic fill_random(input int n, input int w);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                mats[0][r][c] = rand_elem(w);
                mats[1][r][c] = rand_elem(w);
            end
    endtask

    task automatic fill_const(input int n, input longint av, input longint bv);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                mats[0][r][c] = av;
                mats[1][r][c] = bv;
            end
    endtask

    // Exact integer product, then reduced to W bits by the build's rule.
    task automatic model(input int n, input int w);
        longint acc, e, maxv, minv, span;
        span    = longint'(1) << w;
        maxv    = (longint'(1) << (w - 1)) - 1;
        minv    = -maxv - 1;
        exp_ovf = 1'b0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                acc = 0;
                for (int k = 0; k < n; k++) acc += mats[0][r][k] * mats[1][k][c];
`ifdef SATURATE_EN
                if (acc > maxv)      e = maxv;
                else if (acc < minv) e = minv;
                else                 e = acc;
`else
                e = acc & (span - 1);
                if (e > maxv) e -= span;
`endif
                if (e != acc) exp_ovf = 1'b1;
                mats[2][r][c] = e;
            end
    endtask

    // One operation on instance s. glitch_edge > 0 pulses start again at that
    // edge after acceptance (with scrambled operands); b2b leaves the bench in
    // the done cycle so the caller can start the next operation there.
    task automatic run_op(input int s, input int n, input int w, input string tag,
                          input int glitch_edge, input bit b2b);
        int     cnt;
        bit     got;
        longint mask;
        mask = (longint'(1) << w) - 1;
        sel  = s;
        set_ops(s, pack_mat(0, n, w), pack_mat(1, n, w));
        @(negedge clock);
        set_start(s, 1'b1);
        @(posedge clock);
        #1;
        set_start(s, 1'b0);
        check({tag, " accept busy"}, 64'(cur_busy), 64'd1);
        check({tag, " accept done"}, 64'(cur_done), 64'd0);
        set_ops(s, rand_vec(), rand_vec());
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < n + 4) begin
            @(negedge clock);
            if (cnt + 1 == glitch_edge) set_start(s, 1'b1);
            @(posedge clock);
            #1;
            set_start(s, 1'b0);
            cnt++;
            if (cur_done) got = 1'b1;
            else check($sformatf("%s busy edge %0d", tag, cnt), 64'(cur_busy), 64'd1);
        end
        check({tag, " done seen"}, 64'(got), 64'd1);
        // Acceptance edge plus n further edges: done follows the n-th.
        check({tag, " latency"}, 64'(cnt), 64'(n));
        check({tag, " busy at done"}, 64'(cur_busy), 64'd0);
        check({tag, " overflow"}, 64'(cur_ovf), 64'(exp_ovf));
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                check($sformatf("%s r%0d c%0d", tag, r, c),
                      64'(cur_res[(r * n + c) * w +: 16]) & mask,
                      64'(mats[2][r][c] & mask));
        if (!b2b) begin
            @(posedge clock);
            #1;
            check({tag, " done width"}, 64'(cur_done), 64'd0);
            check({tag, " idle busy"}, 64'(cur_busy), 64'd0);
        end
    endtask

    initial begin
        int dones;

        reset_n = 1'b0;
        start5 = 1'b0; start2 = 1'b0; start16 = 1'b0;
        a5 = '0; b5 = '0; a2 = '0; b2 = '0; a16 = '0; b16 = '0;
        sel = 0;

        #1;
        check("reset result", 64'(cur_res != '0), 64'd0);
        check("reset busy", 64'(cur_busy), 64'd0);
        check("reset done", 64'(cur_done), 64'd0);
        check("reset overflow", 64'(cur_ovf), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Identity times a counting matrix returns the counting matrix.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                mats[0][r][c] = (r == c) ? 1 : 0;
                mats[1][r][c] = r * 5 + c;
            end
        model(5, 8);
        run_op(0, 5, 8, "ident", -1, 1'b0);
        check("ident r4c3 literal", 64'(cur_res[(4 * 5 + 3) * 8 +: 8]), 64'd23);

        // All 127: exact sum 80645 = 0x13B05.
        fill_const(5, 127, 127);
        model(5, 8);
        run_op(0, 5, 8, "all127", -1, 1'b0);
`ifdef SATURATE_EN
        check("all127 r0c0 literal", 64'(cur_res[7:0]), 64'h7F);
`else
        check("all127 r0c0 literal", 64'(cur_res[7:0]), 64'h05);
`endif
        check("all127 overflow held", 64'(cur_ovf), 64'd1);

        // -128 x 127: exact sum -81280.
        fill_const(5, -128, 127);
        model(5, 8);
        run_op(0, 5, 8, "neg128", -1, 1'b0);
        check("neg128 r2c2 literal", 64'(cur_res[(2 * 5 + 2) * 8 +: 8]), 64'h80);

        // Start during busy is ignored; start in the done cycle is accepted.
        fill_random(5, 8);
        model(5, 8);
        run_op(0, 5, 8, "glitch", 2, 1'b1);
        fill_random(5, 8);
        model(5, 8);
        run_op(0, 5, 8, "b2b", -1, 1'b0);

        // Asynchronous reset after row 1 has been written.
        fill_const(5, 127, 127);
        sel = 0;
        set_ops(0, pack_mat(0, 5, 8), pack_mat(1, 5, 8));
        @(negedge clock);
        start5 = 1'b1;
        @(posedge clock);
        #1;
        start5 = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("pre-abort result", 64'(cur_res != '0), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort result", 64'(cur_res != '0), 64'd0);
        check("abort busy", 64'(cur_busy), 64'd0);
        check("abort done", 64'(cur_done), 64'd0);
        check("abort overflow", 64'(cur_ovf), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (cur_done) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        fill_random(5, 8);
        model(5, 8);
        run_op(0, 5, 8, "post-abort", -1, 1'b0);

        // N=2, W=4: random plus the most-negative corner.
        for (int i = 0; i < 4; i++) begin
            fill_random(2, 4);
            model(2, 4);
            run_op(1, 2, 4, $sformatf("n2 rnd%0d", i), -1, 1'b0);
        end
        fill_const(2, -8, -8);
        model(2, 4);
        run_op(1, 2, 4, "n2 min", -1, 1'b0);

        // N=16, W=16: random plus a corner that needs the full accumulator.
        for (int i = 0; i < 2; i++) begin
            fill_random(16, 16);
            model(16, 16);
            run_op(2, 16, 16, $sformatf("n16 rnd%0d", i), -1, 1'b0);
        end
        fill_const(16, -32768, -32768);
        model(16, 16);
        run_op(2, 16, 16, "n16 min", -1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
